// File: rtl/duty_slew_if.sv
// Command/target and duty/direction bundle between the drive-command source
// and the duty_slew stage feeding the PWM generator.
interface duty_slew_if;
    logic [10:0] cmd;
    logic        cmd_vld;
    logic        en;
    logic        pwm_wrap;
    logic [9:0]  duty;
    logic        dir;
    logic        busy;

    modport master (
        output cmd, cmd_vld, en, pwm_wrap,
        input  duty, dir, busy
    );

    modport slave (
        input  cmd, cmd_vld, en, pwm_wrap,
        output duty, dir, busy
    );
endinterface

// File: rtl/duty_slew.sv
// Turns a signed drive command into a clamped, deadbanded PWM duty that moves
// at most STEP per PWM period, and only reverses the H-bridge direction after
// ramping to zero and sitting there for DEAD_PERIODS periods.
module duty_slew #(
    parameter int STEP         = 8,
    parameter int MAX_DUTY     = 1000,
    parameter int DEADBAND     = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    duty_slew_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RAMP  = 2'd1;
    localparam logic [1:0] S_DECEL = 2'd2;
    localparam logic [1:0] S_DEAD  = 2'd3;

    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] MAX_W     = 11'(MAX_DUTY);
    localparam logic [10:0] DB_W      = 11'(DEADBAND);
    localparam logic [3:0]  DEAD_LAST = 4'(DEAD_PERIODS - 1);

    logic [1:0]  state_q, state_d;
    logic [9:0]  duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        busy_q, busy_d;
    logic [9:0]  tgt_mag_q, tgt_mag_d;
    logic        tgt_dir_q, tgt_dir_d;
    logic [3:0]  dead_cnt_q, dead_cnt_d;

    logic [10:0] cmd_mag;
    logic [9:0]  cap_mag;
    logic [9:0]  eff_mag;
    logic        eff_dir;
    logic [9:0]  step_res;

    // Moves cur one slew step toward goal without overshooting; 11-bit math so
    // neither direction can wrap around.
    function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] goal);
        logic [10:0] c, g, up, dn;
        c  = {1'b0, cur};
        g  = {1'b0, goal};
        up = c + STEP_W;
        dn = c - STEP_W;
        step_toward = cur;
        if (c < g) begin
            step_toward = (up > g) ? goal : up[9:0];
        end else if (c > g) begin
            step_toward = (c >= g + STEP_W) ? dn[9:0] : goal;
        end
    endfunction

    // Magnitude of the incoming command with deadband and ceiling applied.
    always_comb begin
        cmd_mag = bus.cmd[10] ? (~bus.cmd + 11'd1) : bus.cmd;
        if (cmd_mag < DB_W) begin
            cap_mag = '0;
        end else if (cmd_mag > MAX_W) begin
            cap_mag = MAX_W[9:0];
        end else begin
            cap_mag = cmd_mag[9:0];
        end
    end

    // Target register plus the per-wrap slew/reversal state machine.
    always_comb begin
        tgt_mag_d  = tgt_mag_q;
        tgt_dir_d  = tgt_dir_q;
        state_d    = state_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        dead_cnt_d = dead_cnt_q;
        eff_mag    = bus.en ? tgt_mag_q : 10'd0;
        eff_dir    = bus.en ? tgt_dir_q : dir_q;
        step_res   = step_toward(duty_q, (state_q == S_DECEL) ? 10'd0 : eff_mag);

        if (bus.cmd_vld) begin
            tgt_mag_d = cap_mag;
            if (cap_mag != 10'd0) begin
                tgt_dir_d = bus.cmd[10];
            end
        end

        if (bus.pwm_wrap) begin
            case (state_q)
                S_IDLE: begin
                    if (eff_dir != dir_q && duty_q != 10'd0) begin
                        state_d = S_DECEL;
                    end else if (eff_dir != dir_q) begin
                        state_d    = S_DEAD;
                        dead_cnt_d = '0;
                    end else if (duty_q != eff_mag) begin
                        state_d = S_RAMP;
                        duty_d  = step_res;
                    end
                end
                S_RAMP: begin
                    if (eff_dir != dir_q) begin
                        state_d = S_DECEL;
                    end else begin
                        duty_d = step_res;
                        if (step_res == eff_mag) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DECEL: begin
                    if (eff_dir == dir_q) begin
                        state_d = S_RAMP;
                    end else begin
                        duty_d = step_res;
                        if (step_res == 10'd0) begin
                            state_d    = S_DEAD;
                            dead_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    if (dead_cnt_q == DEAD_LAST) begin
                        dir_d   = eff_dir;
                        state_d = (eff_mag == 10'd0) ? S_IDLE : S_RAMP;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 4'd1;
                    end
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            tgt_mag_q  <= '0;
            tgt_dir_q  <= 1'b0;
            dead_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            tgt_mag_q  <= tgt_mag_d;
            tgt_dir_q  <= tgt_dir_d;
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign bus.duty = duty_q;
    assign bus.dir  = dir_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_duty_slew.sv
// Bench for duty_slew: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the slew/reversal rules.
module tb_duty_slew;

    localparam int STEP     = 8;
    localparam int MAX_DUTY = 1000;
    localparam int DEADBAND = 16;
    localparam int DEAD_P   = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RAMP  = 1;
    localparam int M_DECEL = 2;
    localparam int M_DEAD  = 3;

    logic clk = 1'b0;
    logic rst_n;

    duty_slew_if bus_if ();

    duty_slew dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_duty, m_tmag, m_mode, m_dead_done;
    bit m_dir, m_tdir;
    int prev_duty;
    bit prev_dir;
    int cur_cmd;
    bit cur_en;

    function automatic int toward(input int d, input int g);
        if (d < g) return (d + STEP < g) ? d + STEP : g;
        if (d > g) return (d - STEP > g) ? d - STEP : g;
        return d;
    endfunction

    task automatic modelReset();
        m_duty = 0; m_dir = 0; m_tmag = 0; m_tdir = 0;
        m_mode = M_IDLE; m_dead_done = 0;
        prev_duty = 0; prev_dir = 0;
    endtask

    task automatic modelClock(input int c, input bit v, input bit e, input bit w);
        int em, mag, tm;
        bit ed, rev;
        em  = e ? m_tmag : 0;
        ed  = e ? m_tdir : m_dir;
        rev = (ed != m_dir);
        if (w) begin
            case (m_mode)
                M_IDLE: begin
                    if (rev && m_duty != 0) m_mode = M_DECEL;
                    else if (rev) begin m_mode = M_DEAD; m_dead_done = 0; end
                    else if (m_duty != em) begin m_duty = toward(m_duty, em); m_mode = M_RAMP; end
                end
                M_RAMP: begin
                    if (rev) m_mode = M_DECEL;
                    else begin
                        m_duty = toward(m_duty, em);
                        if (m_duty == em) m_mode = M_IDLE;
                    end
                end
                M_DECEL: begin
                    if (!rev) m_mode = M_RAMP;
                    else begin
                        m_duty = toward(m_duty, 0);
                        if (m_duty == 0) begin m_mode = M_DEAD; m_dead_done = 0; end
                    end
                end
                default: begin
                    if (m_dead_done + 1 >= DEAD_P) begin
                        m_dir  = ed;
                        m_mode = (em == 0) ? M_IDLE : M_RAMP;
                    end else begin
                        m_dead_done++;
                    end
                end
            endcase
        end
        if (v) begin
            mag = (c < 0) ? -c : c;
            tm  = (mag < DEADBAND) ? 0 : ((mag > MAX_DUTY) ? MAX_DUTY : mag);
            if (tm != 0) m_tdir = (c < 0);
            m_tmag = tm;
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (bus_if.duty === 10'(m_duty)) else begin
            errors++;
            $display("[TB] FAIL %s duty: got %0d expected %0d", tag, bus_if.duty, m_duty);
            $error("[TB] %s duty", tag);
        end
        checks++;
        assert (bus_if.dir === m_dir) else begin
            errors++;
            $display("[TB] FAIL %s dir: got %0b expected %0b", tag, bus_if.dir, m_dir);
            $error("[TB] %s dir", tag);
        end
        checks++;
        assert (bus_if.busy === (m_mode != M_IDLE)) else begin
            errors++;
            $display("[TB] FAIL %s busy: got %0b expected %0b", tag, bus_if.busy, m_mode != M_IDLE);
            $error("[TB] %s busy", tag);
        end
        if (prev_duty != 0) begin
            checks++;
            assert (bus_if.dir === prev_dir) else begin
                errors++;
                $display("[TB] FAIL %s dir_hold: got %0b expected %0b", tag, bus_if.dir, prev_dir);
                $error("[TB] %s dir_hold", tag);
            end
        end
        prev_duty = int'(bus_if.duty);
        prev_dir  = bus_if.dir;
    endtask

    task automatic checkValue(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
            $error("[TB] %s", tag);
        end
    endtask

    task automatic applyStimulus(input int c, input bit v, input bit e, input bit w, input string tag);
        bus_if.cmd      = 11'(c);
        bus_if.cmd_vld  = v;
        bus_if.en       = e;
        bus_if.pwm_wrap = w;
        @(posedge clk);
        modelClock(c, v, e, w);
        #1;
        checkOutput(tag);
    endtask

    task automatic capture(input int c, input string tag);
        cur_cmd = c;
        applyStimulus(c, 1'b1, cur_en, 1'b0, tag);
    endtask

    // One wrap strobe followed by one quiet cycle.
    task automatic wrapOnce(input string tag);
        applyStimulus(cur_cmd, 1'b0, cur_en, 1'b1, tag);
        applyStimulus(cur_cmd, 1'b0, cur_en, 1'b0, tag);
    endtask

    task automatic wraps(input int n, input string tag);
        for (int i = 0; i < n; i++) wrapOnce(tag);
    endtask

    // Pulse reset away from the clock edge and check outputs before any edge.
    task automatic resetDut(input string tag);
        rst_n = 1'b0;
        bus_if.cmd_vld  = 1'b0;
        bus_if.pwm_wrap = 1'b0;
        #2;
        modelReset();
        checkOutput(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit reached;
        int c;
        bit v, e, w;
        rst_n = 1'b1;
        cur_en = 1'b1;
        cur_cmd = 0;
        bus_if.cmd = '0;
        bus_if.cmd_vld = 1'b0;
        bus_if.en = 1'b1;
        bus_if.pwm_wrap = 1'b0;
        modelReset();

        $display("[TB] reset and +200 ramp");
        resetDut("reset");
        capture(200, "cap200");
        for (int i = 1; i <= 30; i++) begin
            wrapOnce("ramp200");
            checkValue("ramp200_duty", int'(bus_if.duty), (8 * i < 200) ? 8 * i : 200);
            if (i == 24) checkValue("ramp200_busy24", int'(bus_if.busy), 1);
            if (i == 25) checkValue("ramp200_busy25", int'(bus_if.busy), 0);
        end

        $display("[TB] -1024 from zero");
        resetDut("reset2");
        capture(-1024, "cap_neg1024");
        for (int i = 1; i <= 130; i++) begin
            wrapOnce("neg1024");
            if (i <= 2) checkValue("neg1024_dir_early", int'(bus_if.dir), 0);
            if (i == 3) checkValue("neg1024_dir_flip", int'(bus_if.dir), 1);
            if (i <= 3) checkValue("neg1024_duty_dead", int'(bus_if.duty), 0);
            if (i >= 4) checkValue("neg1024_duty", int'(bus_if.duty),
                                   (8 * (i - 3) < MAX_DUTY) ? 8 * (i - 3) : MAX_DUTY);
        end

        $display("[TB] +200 to -100 reversal");
        resetDut("reset3");
        capture(200, "cap200b");
        wraps(30, "up200");
        capture(-100, "cap_neg100");
        wraps(45, "rev100");
        checkValue("rev100_duty", int'(bus_if.duty), 100);
        checkValue("rev100_dir", int'(bus_if.dir), 1);

        $display("[TB] deadband commands");
        resetDut("reset4");
        capture(40, "cap40");
        wraps(6, "up40");
        capture(15, "cap15");
        wraps(2, "db15");
        capture(-15, "cap_neg15");
        wraps(6, "db_neg15");
        checkValue("db_duty", int'(bus_if.duty), 0);
        checkValue("db_dir", int'(bus_if.dir), 0);

        $display("[TB] enable coast-down");
        resetDut("reset5");
        capture(400, "cap400");
        wraps(20, "up160");
        checkValue("en_at160", int'(bus_if.duty), 160);
        cur_en = 1'b0;
        wraps(25, "coast");
        checkValue("coast_duty", int'(bus_if.duty), 0);
        cur_en = 1'b1;
        wraps(55, "resume");
        checkValue("resume_duty", int'(bus_if.duty), 400);

        $display("[TB] decel abort and coincident capture");
        capture(-300, "cap_neg300");
        wraps(5, "decel");
        cur_cmd = 300;
        applyStimulus(300, 1'b1, 1'b1, 1'b1, "coincident");
        checkValue("coincident_duty", int'(bus_if.duty), 360);
        wrapOnce("abort");
        checkValue("abort_duty", int'(bus_if.duty), 360);
        wrapOnce("abort_step");
        checkValue("abort_step_duty", int'(bus_if.duty), 352);
        checkValue("abort_dir", int'(bus_if.dir), 0);

        $display("[TB] reset mid-DEAD");
        capture(-300, "cap_neg300b");
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            wrapOnce("to_dead");
            if (m_mode == M_DEAD) reached = 1'b1;
        end
        checkValue("dead_reached", int'(reached), 1);
        resetDut("reset_dead");

        $display("[TB] DEAD completes after command returns");
        capture(-100, "cap_neg100b");
        wrapOnce("enter_dead");
        capture(100, "cap100_back");
        wraps(3, "dead_done");
        checkValue("dead_back_dir", int'(bus_if.dir), 0);
        checkValue("dead_back_duty", int'(bus_if.duty), 8);

        $display("[TB] random traffic");
        resetDut("reset_rand");
        for (int i = 0; i < 1500; i++) begin
            c = int'($urandom_range(0, 2047)) - 1024;
            v = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 2) == 0);
            applyStimulus(c, v, e, w, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/duty_slew.md
Name: duty_slew

Overview:
- Upstream stage of the 10-bit PWM generator; produces its `duty` input plus a direction bit for the H-bridge select.
- Converts a signed 11-bit drive command into a clamped, deadbanded magnitude.
- Slew-limits duty changes, one step per PWM period, so the generator never sees a large jump.
- Enforces ramp-to-zero plus a dead interval before any direction reversal.

Parameters:
- STEP, 8: max duty change (LSBs) per PWM period.
- MAX_DUTY, 1000: saturation ceiling for the duty output, 1..1023.
- DEADBAND, 16: command magnitudes below this map to a target of 0.
- DEAD_PERIODS, 2: PWM periods held at duty 0 before dir flips, 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd  in  11  signed two's-complement drive command.
- cmd_vld  in  1  cmd is captured into the target register on any cycle this is high.
- en  in  1  when low, the target is forced to 0 (controlled coast-down); dir is held.
- pwm_wrap  in  1  one-cycle strobe from the PWM counter terminal count (cnt==1023).
- duty  out  10  duty to the PWM generator; registered.
- dir  out  1  0=forward, 1=reverse; registered.
- busy  out  1  high whenever state != IDLE; registered.

Behaviour:
- Reset (async): duty=0, dir=0, busy=0, state=IDLE, tgt_mag=0, tgt_dir=0, dead_cnt=0.

Target capture (cmd_vld=1):
- mag = |cmd|, computed in 11 bits, so -1024 gives 1024.
- tgt_mag = 0 if mag<DEADBAND; else min(mag, MAX_DUTY).
- tgt_dir = cmd[10] if tgt_mag!=0; else tgt_dir is unchanged, so a zero command never requests a reversal.
- Latest capture wins. A capture on the same cycle as pwm_wrap does not affect that wrap's step; it is first used at the next wrap.

Effective target:
- eff_mag = en ? tgt_mag : 0.
- eff_dir = en ? tgt_dir : dir.

Update timing:
- duty, dir and state change only on cycles with pwm_wrap=1. The new values are registered, valid the cycle after the strobe, and hold for the full next period.
- Exception: state/busy leave IDLE or re-enter it only at wraps as well. Between wraps all outputs are stable.

Step arithmetic (11-bit, no overflow):
- If duty<g: duty = min(duty+STEP, g).
- If duty>g: duty = max(duty-STEP, g).
- Here g is the goal for the current state.

FSM (evaluated at each pwm_wrap):
- IDLE:
  - if eff_dir!=dir and duty!=0 -> DECEL.
  - else if eff_dir!=dir and duty==0 -> DEAD, with dead_cnt=0.
  - else if duty!=eff_mag -> RAMP, applying the first step on this same wrap.
- RAMP (g=eff_mag):
  - if eff_dir!=dir -> DECEL, with no step on this wrap.
  - else step; if the result equals eff_mag -> IDLE.
- DECEL (g=0):
  - if eff_dir==dir again -> RAMP, with no step this wrap (no zero crossing, no dead time).
  - else step toward 0; when the result is 0 -> DEAD, dead_cnt=0.
- DEAD: duty held 0; dead_cnt increments per wrap.
  - When dead_cnt reaches DEAD_PERIODS-1 on a wrap: dir=eff_dir, then -> RAMP, or -> IDLE if eff_mag==0.
  - DEAD always completes, even if the command returns to the original direction meanwhile; dir then stays unchanged.

Invariants:
- dir never changes while duty!=0.
- duty <= MAX_DUTY always.
- |duty change| <= STEP per wrap.

Other rules:
- pwm_wrap asserted on consecutive cycles is treated as independent wraps (one step each).
- Async reset mid-ramp/DEAD returns everything to reset values immediately; the next command starts from duty 0, dir 0.

Test Plan:
- Reset, cmd=+200 vld, 30 wraps -> duty 8,16,...,200; reaches 200 on wrap 25, busy drops with that wrap, dir=0.
- cmd=-1024 from duty 0, dir 0 -> dir=1 after 2 dead wraps, then duty ramps by 8 to clamp 1000, never 1023/1024.
- At duty=+200, cmd=-100 -> duty falls 192..0 over 25 wraps; 2 wraps at 0; dir becomes 1; ramps to 100; dir never toggles while duty!=0.
- cmd=+15 and cmd=-15 (deadband 16) from duty 40 -> ramps 32,24,...,0; dir unchanged, no DEAD entry.
- At duty=160 ramping up to 400, en=0 -> ramps down to 0, dir held. en=1 -> resumes toward 400.
- During DECEL, cmd back to original direction -> RAMP next wrap, no dead time. cmd_vld coincident with pwm_wrap -> that step uses the old target. Async rst_n pulse mid-DEAD -> duty=0, dir=0, busy=0 immediately.
